ctrl_nibble_sequencer: RTL and testbench
========================================

// Module: ctrl_nibble_sequencer
// PURPOSE
// - Scheduler in front of the Lab 6 control decoder. It owns ctrl_nibble, the 4-bit command nibble driven into the datapath.
// - Shares ctrl_nibble between two sources: manual switches (SW) and a small programmable step table replayed autonomously.
// - Each table step is {nibble, dwell}. The block holds each nibble for (dwell+1) clock-enable ticks, then advances.
// PARAMETERS
// - NSTEPS   8  number of table entries (power of 2, >=2)
// - DWELL_W  4  dwell counter width; per-step hold is 1..2^DWELL_W ticks
// PORTS
// - clk_div      in   1                  divided system clock; single clock domain
// - BTN0         in   1                  reset, synchronous, active-high
// - SW           in   4                  manual nibble / nibble to program
// - dwell_in     in   DWELL_W            dwell to program with load_btn
// - load_btn     in   1                  one-cycle pulse (already debounced): append {SW,dwell_in} to table
// - run_sw       in   1                  level: 1=autonomous replay, 0=manual
// - tick         in   1                  clock enable for dwell countdown
// - ctrl_nibble  out  4                  registered command nibble to the datapath
// - ctrl_strobe  out  1                  one-cycle pulse whenever ctrl_nibble takes a new value
// - step_idx     out  $clog2(NSTEPS)     index of the step currently driving ctrl_nibble
// - step_count   out  $clog2(NSTEPS)+1   number of programmed steps
// - busy         out  1                  1 in FETCH/DWELL/DONE
// BEHAVIOUR
// - Reset (BTN0=1 at a clk_div edge): state=MANUAL; ctrl_nibble=0; ctrl_strobe=0; step_idx=0; step_count=0; busy=0; dwell_cnt=0.
// - Reset does not clear table contents. Reset mid-replay aborts immediately.
// - MANUAL:
//   - ctrl_nibble<=SW, one-cycle latency.
//   - ctrl_strobe=1 in the cycle after SW differs from the current ctrl_nibble.
//   - load_btn writes table[step_count]<={SW,dwell_in} and increments step_count.
//   - When step_count==NSTEPS, load_btn is ignored (saturate, no wrap).
//   - run_sw=1 with step_count>0 -> FETCH with step_idx=0. With step_count==0, stay in MANUAL.
// - FETCH (exactly 1 cycle):
//   - ctrl_nibble<=table[step_idx].nib; dwell_cnt<=table[step_idx].dwell; ctrl_strobe=1, even if the nibble is unchanged.
//   - -> DWELL.
// - DWELL:
//   - On tick=1 with dwell_cnt>0: dwell_cnt decrements.
//   - On tick=1 with dwell_cnt==0:
//     - If step_idx==step_count-1, step_idx wraps to 0. Otherwise step_idx increments.
//     - -> FETCH.
//   - tick=0: hold.
// - Priority:
//   - BTN0 > run_sw=0 > tick.
//   - run_sw=0 in FETCH/DWELL/DONE -> MANUAL next cycle. step_idx resets to 0.
//   - ctrl_nibble resumes following SW one cycle later.
// - load_btn outside MANUAL is ignored; the table is never written during replay.
// - Latency: run_sw rise -> first strobe = 2 cycles (MANUAL->FETCH->strobe registered).
// - Width rules: dwell compare/decrement are unsigned DWELL_W. step_idx wrap compares against step_count-1, never NSTEPS-1.
// CONFIGURATION
// - Macro CTRL_SEQ_ONESHOT_EN:
//   - Defined: after the last step's dwell expires, go to DONE. DONE holds the last nibble with busy=1 and no strobes until run_sw=0.
//   - Undefined: the program loops indefinitely; DONE state is not generated.
// STRUCTURE
// - Package ctrl_seq_pkg:
//   - State localparams MANUAL/FETCH/DWELL/DONE, 2-bit encoding.
//   - NIB_W=4.
//   - Step-word layout: nib at [NIB_W+DWELL_W-1:DWELL_W], dwell at [DWELL_W-1:0].
// - Sub-module ctrl_step_table:
//   - NSTEPS x (4+DWELL_W) register file; one synchronous write port, one combinational read port.
//   - No reset on storage.
// - Top level: FSM, dwell counter, step pointers, output registers.
// TESTING
// - Reset/manual: BTN0=1 for 3 cycles, SW=4'b0101, BTN0=0.
//   -> ctrl_nibble=0 during reset; =4'b0101 one cycle after release; one ctrl_strobe.
// - Program+loop: load {4'h1,d=0},{4'h2,d=2},{4'h4,d=1}; tick held 1; run_sw=1.
//   -> nibble sequence 1,2,4,1... (holds 1,3,2 ticks); a strobe on every FETCH; step_idx wraps 2->0.
// - Empty run: step_count=0, run_sw=1 -> stays MANUAL, busy=0, ctrl_nibble tracks SW.
// - Saturation: load_btn 10 times with NSTEPS=8 -> step_count=8; entries 0-7 hold the first 8 loads.
// - Abort: run_sw=0 mid-DWELL of step 1, SW=4'b1111 -> MANUAL next cycle, step_idx=0, ctrl_nibble=4'hF one cycle later.
// - Stall/oneshot: tick=0 for 20 cycles in DWELL -> no advance. With CTRL_SEQ_ONESHOT_EN, the 3-step program ends in DONE holding 4'h4.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared types and layout constants for the control-nibble sequencer.
// Step word = {nib, dwell}; nib occupies the upper NIB_W bits.
package ctrl_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    FETCH  = 2'd1,
    DWELL  = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  function automatic int step_word_w(input int dwell_w);
    return NIB_W + dwell_w;
  endfunction

endpackage

// File: rtl/ctrl_nibble_sequencer_if.sv
// Operator/datapath-facing signals of the sequencer; master drives the
// switches and enables, slave is the sequencer itself.
interface ctrl_nibble_sequencer_if #(
  parameter int NSTEPS  = 8,
  parameter int DWELL_W = 4
);
  localparam int IW = $clog2(NSTEPS);

  logic [3:0]         SW;
  logic [DWELL_W-1:0] dwell_in;
  logic               load_btn;
  logic               run_sw;
  logic               tick;
  logic [3:0]         ctrl_nibble;
  logic               ctrl_strobe;
  logic [IW-1:0]      step_idx;
  logic [IW:0]        step_count;
  logic               busy;

  modport master (
    output SW, dwell_in, load_btn, run_sw, tick,
    input  ctrl_nibble, ctrl_strobe, step_idx, step_count, busy
  );

  modport slave (
    input  SW, dwell_in, load_btn, run_sw, tick,
    output ctrl_nibble, ctrl_strobe, step_idx, step_count, busy
  );
endinterface

// File: rtl/ctrl_step_table.sv
// Step program storage: one synchronous write port, one combinational read
// port. Contents are intentionally left unreset so a program survives BTN0.
module ctrl_step_table #(
  parameter int NSTEPS = 8,
  parameter int WORD_W = 8
) (
  input  logic                      clk_div,
  input  logic                      we_i,
  input  logic [$clog2(NSTEPS)-1:0] waddr_i,
  input  logic [WORD_W-1:0]         wdata_i,
  input  logic [$clog2(NSTEPS)-1:0] raddr_i,
  output logic [WORD_W-1:0]         rdata_o
);

  logic [WORD_W-1:0] mem_q [NSTEPS];

  always_ff @(posedge clk_div) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ctrl_nibble_sequencer.sv
// Owns ctrl_nibble: follows SW manually or replays the programmed step table.
// Build option CTRL_SEQ_ONESHOT_EN: stop in DONE after the last step instead of looping.
//
// state  | meaning
// MANUAL | ctrl_nibble follows SW; loads append to the table
// FETCH  | present table[step_idx] and reload the dwell counter (1 cycle)
// DWELL  | hold the nibble until the dwell counter expires on a tick
// DONE   | one-shot build only: hold last nibble until run_sw drops
module ctrl_nibble_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int NSTEPS  = 8,
  parameter int DWELL_W = 4
) (
  input  logic                   clk_div,
  input  logic                   BTN0,
  ctrl_nibble_sequencer_if.slave bus
);

  localparam int IW     = $clog2(NSTEPS);
  localparam int CW     = IW + 1;
  localparam int WORD_W = step_word_w(DWELL_W);

  seq_state_e         state_q;
  logic [NIB_W-1:0]   nib_q;
  logic               strobe_q;
  logic               busy_q;
  logic [IW-1:0]      idx_q;
  logic [CW-1:0]      count_q;
  logic [DWELL_W-1:0] dwell_q;

  logic [WORD_W-1:0]  rd_word;
  logic [NIB_W-1:0]   rd_nib;
  logic [DWELL_W-1:0] rd_dwell;
  logic               load_ok;
  logic               last_step;

  assign rd_nib   = rd_word[WORD_W-1:DWELL_W];
  assign rd_dwell = rd_word[DWELL_W-1:0];

  // Saturating append: a full table silently ignores further loads.
  assign load_ok   = !BTN0 && (state_q == MANUAL) && bus.load_btn
                     && (count_q != CW'(NSTEPS));
  assign last_step = ({1'b0, idx_q} == (count_q - 1'b1));

  ctrl_step_table #(
    .NSTEPS (NSTEPS),
    .WORD_W (WORD_W)
  ) u_table (
    .clk_div (clk_div),
    .we_i    (load_ok),
    .waddr_i (count_q[IW-1:0]),
    .wdata_i ({bus.SW, bus.dwell_in}),
    .raddr_i (idx_q),
    .rdata_o (rd_word)
  );

  always_ff @(posedge clk_div) begin
    if (BTN0) begin
      state_q  <= MANUAL;
      nib_q    <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      idx_q    <= '0;
      count_q  <= '0;
      dwell_q  <= '0;
    end else begin
      strobe_q <= 1'b0;
      if (load_ok) begin
        count_q <= count_q + 1'b1;
      end
      case (state_q)
        MANUAL: begin
          nib_q    <= bus.SW;
          strobe_q <= (bus.SW != nib_q);
          if (bus.run_sw && (count_q != '0)) begin
            state_q <= FETCH;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          if (!bus.run_sw) begin
            state_q <= MANUAL;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            nib_q    <= rd_nib;
            dwell_q  <= rd_dwell;
            strobe_q <= 1'b1;
            state_q  <= DWELL;
          end
        end
        DWELL: begin
          if (!bus.run_sw) begin
            state_q <= MANUAL;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end else if (bus.tick) begin
            if (dwell_q != '0) begin
              dwell_q <= dwell_q - 1'b1;
            end else if (last_step) begin
`ifdef CTRL_SEQ_ONESHOT_EN
              state_q <= DONE;
`else
              idx_q   <= '0;
              state_q <= FETCH;
`endif
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= FETCH;
            end
          end
        end
`ifdef CTRL_SEQ_ONESHOT_EN
        DONE: begin
          if (!bus.run_sw) begin
            state_q <= MANUAL;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= MANUAL;
          idx_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ctrl_nibble = nib_q;
  assign bus.ctrl_strobe = strobe_q;
  assign bus.step_idx    = idx_q;
  assign bus.step_count  = count_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ctrl_nibble_sequencer.sv
// Scoreboard bench for ctrl_nibble_sequencer: expected strobes (edge number,
// nibble, step index) are queued from a step-level model and popped by a monitor.
module tb_ctrl_nibble_sequencer;

  localparam int NSTEPS  = 8;
  localparam int DWELL_W = 4;

  logic clk = 1'b0;
  logic btn0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  ctrl_nibble_sequencer_if #(.NSTEPS(NSTEPS), .DWELL_W(DWELL_W)) bif();

  ctrl_nibble_sequencer #(.NSTEPS(NSTEPS), .DWELL_W(DWELL_W)) dut (
    .clk_div (clk),
    .BTN0    (btn0),
    .bus     (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int nib; int idx; } exp_t;
  typedef struct { int nib; int dw; } stp_t;

  exp_t sb[$];
  stp_t mtab[$];
  int   m_nib;
  exp_t mon_e;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void push_exp(input int c, input int nib, input int idx);
    exp_t e;
    e.cyc = c; e.nib = nib; e.idx = idx;
    sb.push_back(e);
  endfunction

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (bif.ctrl_strobe === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_strobe: got nibble %0d at edge %0d, expected none", bif.ctrl_nibble, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("strobe_edge", cyc, mon_e.cyc);
        chk("strobe_nibble", int'(bif.ctrl_nibble), mon_e.nib);
        chk("strobe_idx", int'(bif.step_idx), mon_e.idx);
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_cmp++; n_err++;
      $display("FAIL missing_strobe: got none at edge %0d, expected nibble %0d", cyc, mon_e.nib);
    end
  end

  task automatic step_manual(input int sw, input bit ld, input int dw, input bit run);
    @(negedge clk);
    bif.SW       = 4'(sw);
    bif.dwell_in = 4'(dw);
    bif.load_btn = ld;
    bif.run_sw   = run;
    bif.tick     = 1'($urandom);
    if (sw != m_nib) push_exp(cyc + 1, sw, 0);
    m_nib = sw;
    if (ld && mtab.size() < NSTEPS) mtab.push_back('{sw, dw});
  endtask

  // Called at the negedge following at least one reset edge
  task automatic release_reset(input int sw);
    chk("rst_nibble", int'(bif.ctrl_nibble), 0);
    chk("rst_strobe", int'(bif.ctrl_strobe), 0);
    chk("rst_busy", int'(bif.busy), 0);
    chk("rst_count", int'(bif.step_count), 0);
    chk("rst_idx", int'(bif.step_idx), 0);
    btn0         = 1'b0;
    bif.SW       = 4'(sw);
    bif.run_sw   = 1'b0;
    bif.load_btn = 1'b0;
    mtab.delete();
    if (sw != 0) push_exp(cyc + 1, sw, 0);
    m_nib = sw;
    @(negedge clk);
    chk("rst_release_nibble", int'(bif.ctrl_nibble), sw);
  endtask

  task automatic do_reset(input int sw, input int n);
    repeat (n) begin
      @(negedge clk);
      btn0         = 1'b1;
      bif.SW       = 4'(sw);
      bif.run_sw   = 1'b0;
      bif.load_btn = 1'b0;
    end
    @(negedge clk);
    release_reset(sw);
  endtask

  task automatic load_step(input int nib, input int dw);
    step_manual(nib, 1'b1, dw, 1'b0);
    step_manual(nib, 1'b0, 0, 1'b0);
  endtask

  // Raise run_sw for ncyc cycles of random ticks, then abort or reset.
  task automatic replay(input int ncyc, input int pct, input int sw_end, input bit rst_end);
    int c0, last, f, e, need, s;
    bit t[$];
    step_manual(m_nib, 1'b0, 0, 1'b1);
    c0   = cyc;
    last = c0 + 1 + ncyc;
    for (int i = 0; i < ncyc; i++) t.push_back($urandom_range(99) < pct);
    // Each step: strobe on its fetch edge, then (dwell+1) ticks, then next fetch
    f = c0 + 2;
    s = 0;
    while (f <= last) begin
      push_exp(f, mtab[s].nib, s);
      m_nib = mtab[s].nib;
      need  = mtab[s].dw + 1;
      e     = f;
      while (need > 0 && e < last) begin
        e++;
        if (t[e - c0 - 2]) need--;
      end
      if (need > 0) break;
      if (s == mtab.size() - 1) begin
`ifdef CTRL_SEQ_ONESHOT_EN
        break;
`else
        s = 0;
`endif
      end else begin
        s++;
      end
      f = e + 1;
    end
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      bif.tick     = t[i];
      bif.SW       = 4'($urandom_range(15));
      bif.load_btn = 1'($urandom);
      bif.dwell_in = 4'($urandom_range(15));
    end
    @(negedge clk);
    chk("replay_idx", int'(bif.step_idx), s);
    chk("replay_busy", int'(bif.busy), 1);
    chk("replay_count", int'(bif.step_count), mtab.size());
    chk("replay_nibble", int'(bif.ctrl_nibble), m_nib);
    if (rst_end) begin
      btn0         = 1'b1;
      bif.SW       = 4'(sw_end);
      bif.run_sw   = 1'b0;
      bif.load_btn = 1'b0;
      @(negedge clk);
      release_reset(sw_end);
    end else begin
      bif.run_sw   = 1'b0;
      bif.SW       = 4'(sw_end);
      bif.load_btn = 1'b0;
      if (sw_end != m_nib) push_exp(cyc + 2, sw_end, 0);
      @(negedge clk);
      chk("abort_busy", int'(bif.busy), 0);
      chk("abort_idx", int'(bif.step_idx), 0);
      chk("abort_hold_nibble", int'(bif.ctrl_nibble), m_nib);
      m_nib = sw_end;
      @(negedge clk);
      chk("abort_follow_nibble", int'(bif.ctrl_nibble), sw_end);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    btn0         = 1'b1;
    bif.SW       = 4'h0;
    bif.dwell_in = '0;
    bif.load_btn = 1'b0;
    bif.run_sw   = 1'b0;
    bif.tick     = 1'b0;
    m_nib        = 0;

    do_reset(4'b0101, 3);

    // Empty table: run_sw must not leave manual mode
    for (int i = 0; i < 6; i++) step_manual($urandom_range(15), 1'b0, 0, 1'b1);
    step_manual(m_nib, 1'b0, 0, 1'b0);
    chk("empty_run_busy", int'(bif.busy), 0);
    chk("empty_run_idx", int'(bif.step_idx), 0);

    load_step(4'h1, 0);
    load_step(4'h2, 2);
    load_step(4'h4, 1);
    chk("prog_count", int'(bif.step_count), 3);

    replay(30, 100, 4'hA, 1'b0);
    replay(4, 100, 4'hF, 1'b0);
    replay(25, 0, 4'h3, 1'b0);
    replay(60, 50, 4'h6, 1'b1);

    for (int i = 0; i < 10; i++) load_step($urandom_range(15), $urandom_range(15));
    chk("sat_count", int'(bif.step_count), NSTEPS);
    replay(200, 60, $urandom_range(15), 1'b0);

    do_reset($urandom_range(15), 1);
    n = $urandom_range(2, 7);
    for (int i = 0; i < n; i++) load_step($urandom_range(15), $urandom_range(15));
    chk("rand_count", int'(bif.step_count), n);
    replay(120, 40, $urandom_range(15), 1'b0);

    repeat (3) step_manual(m_nib, 1'b0, 0, 1'b0);
    chk("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
